id_branch_unit: RTL
===================

Name: id_branch_unit

Overview:
- Parametrised next-generation ID-stage control-flow unit.
- Combines a BHT of 2-bit saturating counters and a direct-mapped BTB, looked up in IF and trained from resolution in ID.
- Owns flush/redirect generation, a sticky halt flag and saturating performance counters.
- IF consumes the prediction outputs. ID supplies the comparator result (br_en) and the computed branch/jump target.

Parameters:
- width, 32, datapath/PC width
- BHT_ENTRIES, 64, number of 2-bit counters (power of 2, >=4)
- BTB_ENTRIES, 16, number of BTB entries (power of 2, >=2)
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_pc_i  in  width  PC being fetched
- if_pred_taken_o  out  1  predicted taken
- if_pred_target_o  out  width  predicted target
- id_valid_i  in  1  ID holds a real instruction (0 = bubble from hazard NOP)
- id_stall_i  in  1  ID frozen this cycle
- id_pc_i  in  width  PC of the instruction in ID
- id_opcode_i  in  7  rv32i_opcode of the instruction in ID
- id_br_en_i  in  1  comparator result from ID
- id_target_i  in  width  resolved target
- id_pred_taken_i  in  1  prediction carried through IF/ID
- id_pred_target_i  in  width  predicted target carried through IF/ID
- id_flush_o  out  1  flush IF/ID, redirect fetch
- id_redirect_pc_o  out  width  correct next PC
- halt_o  out  1  sticky halt
- br_count_o  out  CNT_WIDTH  resolved control-flow instructions
- mispred_count_o  out  CNT_WIDTH  mispredictions

Behaviour:
- Indexing:
  - bidx = pc[log2(BHT_ENTRIES)+1:2]
  - tidx = pc[log2(BTB_ENTRIES)+1:2]
  - tag = pc[width-1:log2(BTB_ENTRIES)+2]
- BTB entry: {valid, tag, target, uncond}.
- Lookup (combinational from if_pc_i):
  - hit = valid & tag match.
  - if_pred_taken_o = hit & (uncond | bht[bidx][1]).
  - if_pred_target_o = hit ? btb target : if_pc_i+4.
- Read-before-write: a lookup and an update to the same index in the same cycle return the pre-update value.
- Resolution qualifier: res = id_valid_i & ~id_stall_i & opcode in {op_br, op_jal, op_jalr}.
- Actual outcome: actual = (opcode==op_br) ? id_br_en_i : 1.
- Mispredict: mis = (actual != id_pred_taken_i) | (actual & id_pred_target_i != id_target_i).
- Flush/redirect (combinational):
  - id_flush_o = res & mis.
  - id_redirect_pc_o = actual ? id_target_i : id_pc_i+4; value is don't-care when flush=0.
- Training, on the clock edge when res:
  - op_br only: bht[bidx(id_pc_i)] increments if actual, else decrements; saturates at 3 (strongly taken) and 0 (strongly not-taken).
  - If actual: btb[tidx] <= {1, tag, id_target_i, opcode!=op_br}. This overwrites any previous entry, so aliasing replaces.
  - op_br not taken: BTB unchanged.
- Counters, on the clock edge when res:
  - br_count_o increments by 1.
  - mispred_count_o increments by 1 if mis.
  - Both saturate at all-ones with no wrap.
- Halt:
  - halt_o is set on the clock edge when res & actual & (id_target_i == id_pc_i).
  - Once set, it holds until rst.
  - A not-taken self-branch does not set halt.
- Stall: when id_stall_i=1, no flush, no training, no counting, and no halt set. Outputs still reflect the current inputs except id_flush_o, which is 0.
- Bubbles: id_valid_i=0 is treated the same as stall for side-effects and flush.
- Reset values (rst sampled high on an edge):
  - all BHT counters = 01 (weakly not-taken)
  - all BTB valid = 0
  - halt_o = 0
  - both counters = 0
- Reset mid-operation: reset wins over any same-cycle update. In the cycle after reset, if_pred_taken_o=0 and if_pred_target_o=if_pc_i+4 for every PC.
- Latency:
  - Prediction: 0 cycles (combinational).
  - Training: visible to lookups 1 cycle after the resolving edge.
  - Flush: same cycle as resolution.

Test Plan:
- After rst: if_pc_i=0x60 -> if_pred_taken_o=0, if_pred_target_o=0x64; both counters 0; halt_o=0.
- First-encounter branch: op_br at 0x80, br_en=1, target 0x40, pred_taken=0 -> id_flush_o=1, redirect=0x40. Next cycle, lookup 0x80 -> taken=1 (counter 10), target 0x40; mispred_count=1, br_count=1.
- Hysteresis: same branch resolved taken twice, then not-taken once -> counter goes 10 -> 11 -> 10; lookup still predicts taken, target 0x40. The not-taken resolution with pred_taken=1 flushes with redirect 0x84.
- jalr wrong target: jalr at 0x100 previously learned target 0x200; now id_target_i=0x300 with pred 0x200 -> flush=1, redirect 0x300. BTB is updated, so the next lookup of 0x100 gives 0x300 (uncond, predicted taken regardless of BHT).
- Stall/bubble gating: mispredicting op_br with id_stall_i=1, or with id_valid_i=0 -> id_flush_o=0, no BHT/BTB/counter change. Hold 3 cycles, release stall -> exactly one flush and one count increment.
- Halt and saturation: op_br at 0x2C, br_en=1, target 0x2C -> halt_o=1 next cycle, stays 1 after 10 further cycles, cleared by rst. With CNT_WIDTH=4, 17 resolutions -> br_count_o=15.

Source files
------------

// File: rtl/id_branch_unit.sv
// ID-stage control-flow unit: BHT + BTB prediction for IF, resolution/flush in ID,
// sticky halt detection and saturating branch/mispredict counters.
module id_branch_unit #(
  parameter int width       = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     if_pc_i,
  output logic                 if_pred_taken_o,
  output logic [width-1:0]     if_pred_target_o,
  input  logic                 id_valid_i,
  input  logic                 id_stall_i,
  input  logic [width-1:0]     id_pc_i,
  input  logic [6:0]           id_opcode_i,
  input  logic                 id_br_en_i,
  input  logic [width-1:0]     id_target_i,
  input  logic                 id_pred_taken_i,
  input  logic [width-1:0]     id_pred_target_i,
  output logic                 id_flush_o,
  output logic [width-1:0]     id_redirect_pc_o,
  output logic                 halt_o,
  output logic [CNT_WIDTH-1:0] br_count_o,
  output logic [CNT_WIDTH-1:0] mispred_count_o
);

  localparam int BW   = $clog2(BHT_ENTRIES);
  localparam int TW   = $clog2(BTB_ENTRIES);
  localparam int TAGW = width - TW - 2;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [width-1:0]     PC_STEP = width'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]             r_bht       [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] r_btbValid;
  logic [BTB_ENTRIES-1:0] r_btbUncond;
  logic [TAGW-1:0]        r_btbTag    [BTB_ENTRIES];
  logic [width-1:0]       r_btbTarget [BTB_ENTRIES];
  logic                   r_halt;
  logic [CNT_WIDTH-1:0]   r_brCount;
  logic [CNT_WIDTH-1:0]   r_mispredCount;

  logic [BW-1:0]   w_ifBidx;
  logic [TW-1:0]   w_ifTidx;
  logic [TAGW-1:0] w_ifTag;
  logic            w_ifHit;
  logic [BW-1:0]   w_idBidx;
  logic [TW-1:0]   w_idTidx;
  logic [TAGW-1:0] w_idTag;
  logic            w_isBr;
  logic            w_isCf;
  logic            w_res;
  logic            w_actual;
  logic            w_mis;
  logic [1:0]      w_bhtCur;
  logic [1:0]      w_bhtNext;
  logic            w_unused;

  // Low PC bits are always word-aligned and never feed any index or tag.
  assign w_unused = ^{if_pc_i[1:0], id_pc_i[1:0]};

  assign w_ifBidx = if_pc_i[BW+1:2];
  assign w_ifTidx = if_pc_i[TW+1:2];
  assign w_ifTag  = if_pc_i[width-1:TW+2];
  assign w_idBidx = id_pc_i[BW+1:2];
  assign w_idTidx = id_pc_i[TW+1:2];
  assign w_idTag  = id_pc_i[width-1:TW+2];

  assign w_ifHit          = r_btbValid[w_ifTidx] & (r_btbTag[w_ifTidx] == w_ifTag);
  assign if_pred_taken_o  = w_ifHit & (r_btbUncond[w_ifTidx] | r_bht[w_ifBidx][1]);
  assign if_pred_target_o = w_ifHit ? r_btbTarget[w_ifTidx] : if_pc_i + PC_STEP;

  assign w_isBr   = (id_opcode_i == OP_BR);
  assign w_isCf   = w_isBr | (id_opcode_i == OP_JAL) | (id_opcode_i == OP_JALR);
  assign w_res    = id_valid_i & ~id_stall_i & w_isCf;
  assign w_actual = w_isBr ? id_br_en_i : 1'b1;
  assign w_mis    = (w_actual != id_pred_taken_i) |
                    (w_actual & (id_pred_target_i != id_target_i));

  assign id_flush_o       = w_res & w_mis;
  assign id_redirect_pc_o = w_actual ? id_target_i : id_pc_i + PC_STEP;

  assign w_bhtCur  = r_bht[w_idBidx];
  assign w_bhtNext = w_actual ? ((w_bhtCur == 2'b11) ? 2'b11 : w_bhtCur + 2'b01)
                              : ((w_bhtCur == 2'b00) ? 2'b00 : w_bhtCur - 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (w_res && w_isBr) begin
      r_bht[w_idBidx] <= w_bhtNext;
    end
  end

  // Taken resolutions always overwrite the slot, so aliasing PCs simply replace each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btbValid  <= '0;
      r_btbUncond <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btbTag[i]    <= '0;
        r_btbTarget[i] <= '0;
      end
    end else if (w_res && w_actual) begin
      r_btbValid[w_idTidx]  <= 1'b1;
      r_btbUncond[w_idTidx] <= ~w_isBr;
      r_btbTag[w_idTidx]    <= w_idTag;
      r_btbTarget[w_idTidx] <= id_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_brCount      <= '0;
      r_mispredCount <= '0;
    end else if (w_res) begin
      if (r_brCount != '1) r_brCount <= r_brCount + CNT_ONE;
      if (w_mis && (r_mispredCount != '1)) r_mispredCount <= r_mispredCount + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt <= 1'b0;
    end else if (w_res && w_actual && (id_target_i == id_pc_i)) begin
      r_halt <= 1'b1;
    end
  end

  assign halt_o          = r_halt;
  assign br_count_o      = r_brCount;
  assign mispred_count_o = r_mispredCount;

endmodule
